// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequencer for an iterative AES-128 datapath; owns the 128-bit state register.
// Define AES_ROUND_CTRL_ABORT_EN to add the abort_i input (force IDLE from ROUND/DONE).
`ifndef TEXT_WIDTH
`define TEXT_WIDTH 128
`endif

module aes_round_ctrl #(
  parameter int NR    = 10,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic                   abort_i,
`endif
  input  logic                   pt_valid_i,
  output logic                   pt_ready_o,
  input  logic [`TEXT_WIDTH-1:0] pt_i,
  input  logic [`TEXT_WIDTH-1:0] key_i,
  output logic                   key_load_o,
  output logic [CNT_W-1:0]       rkey_idx_o,
  input  logic                   rkey_valid_i,
  output logic [`TEXT_WIDTH-1:0] round_state_o,
  output logic                   round_last_o,
  input  logic [`TEXT_WIDTH-1:0] round_result_i,
  output logic                   ct_valid_o,
  input  logic                   ct_ready_i,
  output logic [`TEXT_WIDTH-1:0] ct_o,
  output logic                   busy_o
);

  // state | meaning
  // IDLE  | waiting for plaintext/key; pt_ready_o high
  // ROUND | one round per cycle while the round key is valid, otherwise stall
  // DONE  | ciphertext offered until ct_ready_i
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_e;

  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(NR);

  fsm_e                   fsm_q, fsm_d;
  logic [`TEXT_WIDTH-1:0] state_q, state_d;
  logic [CNT_W-1:0]       round_q, round_d;
  logic                   accept;
  logic                   abort;

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign abort = abort_i & (fsm_q != IDLE);
`else
  assign abort = 1'b0;
`endif

  assign accept        = pt_valid_i & (fsm_q == IDLE);
  assign round_state_o = state_q;
  assign ct_o          = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    fsm_d        = fsm_q;
    state_d      = state_q;
    round_d      = round_q;
    pt_ready_o   = 1'b0;
    key_load_o   = 1'b0;
    rkey_idx_o   = '0;
    round_last_o = 1'b0;
    ct_valid_o   = 1'b0;
    busy_o       = (fsm_q != IDLE);

    case (fsm_q)
      IDLE: begin
        pt_ready_o = 1'b1;
        key_load_o = accept;
        if (accept) begin
          state_d = pt_i ^ key_i;
          round_d = CNT_W'(1);
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        rkey_idx_o   = round_q;
        round_last_o = (round_q == LAST_RND);
        if (rkey_valid_i) begin
          state_d = round_result_i;
          if (round_q == LAST_RND) fsm_d = DONE;
          else                     round_d = round_q + CNT_W'(1);
        end
      end
      DONE: begin
        ct_valid_o = 1'b1;
        if (ct_ready_i) begin
          fsm_d   = IDLE;
          round_d = '0;
        end
      end
      default: begin
        fsm_d   = IDLE;
        round_d = '0;
      end
    endcase

    // Abort overrides any transition chosen above; the result is discarded.
    if (abort) begin
      fsm_d   = IDLE;
      state_d = '0;
      round_d = '0;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl with a behavioural AES round unit and key expansion attached.
// Expected ciphertexts are FIPS-197 vectors pushed to a scoreboard on accept.
module tb_aes_round_ctrl;

  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
`ifdef AES_ROUND_CTRL_ABORT_EN
  logic         abort_i = 1'b0;
`endif
  logic         pt_valid_i = 1'b0;
  logic         pt_ready_o;
  logic [127:0] pt_i = '0;
  logic [127:0] key_i = '0;
  logic         key_load_o;
  logic [3:0]   rkey_idx_o;
  logic         rkey_valid_i = 1'b1;
  logic [127:0] round_state_o;
  logic         round_last_o;
  logic [127:0] round_result_i;
  logic         ct_valid_o;
  logic         ct_ready_i = 1'b0;
  logic [127:0] ct_o;
  logic         busy_o;

  logic [127:0] rk [16];
  logic [127:0] exp_q [$];
  int           n_checks = 0;
  int           n_errors = 0;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(10), .CNT_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort_i        (abort_i),
`endif
    .pt_valid_i     (pt_valid_i),
    .pt_ready_o     (pt_ready_o),
    .pt_i           (pt_i),
    .key_i          (key_i),
    .key_load_o     (key_load_o),
    .rkey_idx_o     (rkey_idx_o),
    .rkey_valid_i   (rkey_valid_i),
    .round_state_o  (round_state_o),
    .round_last_o   (round_last_o),
    .round_result_i (round_result_i),
    .ct_valid_o     (ct_valid_o),
    .ct_ready_i     (ct_ready_i),
    .ct_o           (ct_o),
    .busy_o         (busy_o)
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  always @(posedge clk) begin
    if (key_load_o) begin
      for (int r = 0; r < 11; r++) rk[r] <= round_key(key_i, r);
    end
  end

  always_comb round_result_i = aes_round(round_state_o, rk[rkey_idx_o], round_last_o);

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One block end to end: optional stall at stall_rnd, ct backpressure, busy-time offer.
  task automatic encrypt(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] exp,
                         input int stall_rnd, input int stall_n, input int bp_n,
                         input bit offer, input logic [127:0] opt, input logic [127:0] okey);
    int           cyc;
    int           exp_rnd;
    int           stalls;
    logic [127:0] held;
    logic [127:0] exp_v;
    pt_i = pt; key_i = key; pt_valid_i = 1'b1;
    ct_ready_i = (bp_n == 0); rkey_valid_i = 1'b1;
    #1;
    check("pt_ready_idle", 128'(pt_ready_o), 128'(1));
    check("key_load_pulse", 128'(key_load_o), 128'(1));
    exp_q.push_back(exp);
    tick();
    pt_valid_i = 1'b0;
    if (offer) begin
      pt_i = opt; key_i = okey; pt_valid_i = 1'b1;
    end
    #1;
    check("key_load_busy", 128'({key_load_o, pt_ready_o}), 128'(0));
    cyc = 0; exp_rnd = 1; stalls = stall_n;
    while (!ct_valid_o && cyc < 40) begin
      check("rkey_idx", 128'(rkey_idx_o), 128'(exp_rnd));
      check("round_last", 128'(round_last_o), 128'(exp_rnd == 10));
      check("busy_round", 128'({busy_o, pt_ready_o}), 128'(2'b10));
      held = round_state_o;
      if (stalls > 0 && exp_rnd == stall_rnd) begin
        rkey_valid_i = 1'b0;
        tick();
        cyc++; stalls--;
        check("stall_state", round_state_o, held);
        rkey_valid_i = 1'b1;
      end else begin
        tick();
        cyc++;
        if (exp_rnd < 10) exp_rnd++;
      end
    end
    check("latency", 128'(cyc), 128'(10 + stall_n));
    check("ct_valid_rise", 128'(ct_valid_o), 128'(1));
    held = ct_o;
    for (int k = 1; k < bp_n; k++) begin
      tick();
      check("bp_hold", 128'({ct_valid_o, pt_ready_o, busy_o}), 128'(3'b101));
      check("bp_ct_stable", ct_o, held);
    end
    ct_ready_i = 1'b1;
    if (exp_q.size() > 0) exp_v = exp_q.pop_front();
    else exp_v = 'x;
    check("ct_value", ct_o, exp_v);
    tick();
    ct_ready_i = 1'b0;
    check("post_handshake", 128'({pt_ready_o, ct_valid_o, busy_o}), 128'(3'b100));
  endtask

  initial begin
    int n;
    #3;
    check("reset_ctl", 128'({pt_ready_o, busy_o, ct_valid_o, key_load_o, round_last_o, rkey_idx_o}),
          128'(9'b1_0000_0000));
    check("reset_state", round_state_o, 128'(0));
    check("reset_ct", ct_o, 128'(0));
    #9 rst_n = 1'b1;
    tick();

    encrypt(PT1, KEY1, CT1, 0, 0, 0, 1'b0, '0, '0);
    encrypt(PT1, KEY1, CT1, 5, 3, 0, 1'b0, '0, '0);
    encrypt(PT2, KEY2, CT2, 0, 0, 7, 1'b0, '0, '0);
    encrypt(PT1, KEY1, CT1, 0, 0, 2, 1'b1, PT2, KEY2);
    encrypt(PT2, KEY2, CT2, 0, 0, 0, 1'b0, '0, '0);

    // Async reset in round 6, asserted and released mid-cycle.
    pt_i = PT1; key_i = KEY1; pt_valid_i = 1'b1;
    exp_q.push_back(CT1);
    tick();
    pt_valid_i = 1'b0;
    n = 0;
    while (rkey_idx_o != 4'd6 && n < 20) begin
      tick();
      n++;
    end
    check("reach_round6", 128'(rkey_idx_o), 128'(6));
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ctl", 128'({pt_ready_o, busy_o, ct_valid_o, key_load_o, round_last_o, rkey_idx_o}),
          128'(9'b1_0000_0000));
    check("rst_mid_state", round_state_o, 128'(0));
    void'(exp_q.pop_back());
    #3 rst_n = 1'b1;
    tick();
    encrypt(PT1, KEY1, CT1, 0, 0, 0, 1'b0, '0, '0);

`ifdef AES_ROUND_CTRL_ABORT_EN
    pt_i = PT2; key_i = KEY2; pt_valid_i = 1'b1;
    exp_q.push_back(CT2);
    tick();
    pt_valid_i = 1'b0;
    n = 0;
    while (rkey_idx_o != 4'd3 && n < 20) begin
      tick();
      n++;
    end
    check("reach_round3", 128'(rkey_idx_o), 128'(3));
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_idle", 128'({pt_ready_o, busy_o, rkey_idx_o}), 128'(6'b10_0000));
    check("abort_state", round_state_o, 128'(0));
    for (int k = 0; k < 12; k++) begin
      check("abort_no_ct", 128'(ct_valid_o), 128'(0));
      tick();
    end
    void'(exp_q.pop_back());
    encrypt(PT2, KEY2, CT2, 0, 0, 0, 1'b0, '0, '0);
`endif

    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
